config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/config_loader.sv
// rtl/config_loader.sv - serial config loader: sync-word hunt, MSB-first data word, even-parity check
module config_loader #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter int         CFG_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  input  logic             cfg_restart,
  output logic             cfg_ready,
  output logic [CFG_W-1:0] BitFile,
  output logic             cfg_done,
  output logic             cfg_error
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    DATA   = 3'd1,
    PARITY = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       win_q, win_d, win_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] bf_q, bf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             accept;

  assign cfg_ready = (state_q == SYNC) || (state_q == DATA) || (state_q == PARITY);
  assign accept    = cfg_valid && cfg_ready;
  assign win_shift = {win_q[6:0], cfg_bit};
  assign BitFile   = bf_q;
  assign cfg_done  = done_q;
  assign cfg_error = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= SYNC;
      win_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      bf_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      bf_q     <= bf_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    bf_d     = bf_q;
    done_d   = done_q;
    err_d    = err_q;

    // Restart wins over any bit offered on the same edge; flags clear only out of DONE/ERROR.
    if (cfg_restart) begin
      state_d  = SYNC;
      win_d    = '0;
      cnt_d    = '0;
      shadow_d = '0;
      if ((state_q == DONE) || (state_q == ERROR)) begin
        done_d = 1'b0;
        err_d  = 1'b0;
      end
    end else if (accept) begin
      case (state_q)
        SYNC: begin
          win_d = win_shift;
          if (win_shift == SYNC_WORD) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shadow_d = {shadow_q[CFG_W-2:0], cfg_bit};
          if (cnt_q == CNT_W'(CFG_W - 1)) begin
            state_d = PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (((^shadow_q) ^ cfg_bit) == 1'b0) begin
            bf_d    = shadow_q;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ERROR;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

endmodule
